// File: rtl/pipe_hazard_sequencer.sv
// ---------------------------------------------------------------------------
// pipe_hazard_sequencer
//
// Central control for the 8-bit 5-stage pipeline (IF, ID, EX, MEM, WB).
// Sequences idle -> run / single-step pause -> halt drain -> halted, detects
// load-use hazards between EX and ID, and produces the PC / IF-ID enables and
// the IF-ID / ID-EX flush (bubble) controls. A saturating counter records
// every stall or flush cycle for debug readout.
//
// Ports:
//   clk          pipeline clock
//   reset        asynchronous reset, active low (0 = reset)
//   start        pulse: leave IDLE (to RUN, or PAUSE when step_mode=1)
//   step_mode    1 = advance one instruction per step pulse
//   step         pulse: issue one fetch while paused
//   ID_rs1/2     source registers of the instruction in ID
//   ID_use_rs1/2 instruction in ID actually reads rs1 / rs2
//   EX_rd        destination register of the instruction in EX
//   EX_mem_read  instruction in EX is a load
//   EX_redirect  jump / taken branch resolved in EX
//   EX_halt      halt instruction in EX
//   pc_en        PC update enable
//   IF_ID_en     IF/ID register load enable
//   IF_ID_flush  clear IF/ID to a NOP
//   ID_EX_flush  clear ID/EX (bubble insert)
//   halted       pipeline stopped after the halt retired
//   running      state is RUN or PAUSE
//   event_cnt    saturating count of stall and flush cycles
// ---------------------------------------------------------------------------
module pipe_hazard_sequencer #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  input  logic [1:0]       ID_rs1,
  input  logic [1:0]       ID_rs2,
  input  logic             ID_use_rs1,
  input  logic             ID_use_rs2,
  input  logic [1:0]       EX_rd,
  input  logic             EX_mem_read,
  input  logic             EX_redirect,
  input  logic             EX_halt,
  output logic             pc_en,
  output logic             IF_ID_en,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             halted,
  output logic             running,
  output logic [CNT_W-1:0] event_cnt
);

  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DRAIN,
    S_HALTED
  } state_t;

  state_t          state;
  logic [DW-1:0]   drain_cnt;
  logic            step_pend;
  logic            load_use;
  logic            step_req;
  logic            active;
  logic            count_evt;

  assign load_use = EX_mem_read &
                    ((ID_use_rs1 & (ID_rs1 == EX_rd)) |
                     (ID_use_rs2 & (ID_rs2 == EX_rd)));

  // A step seen during a load-use stall is remembered in step_pend so the
  // issue is retried on the following cycles instead of being dropped.
  assign step_req = step | step_pend;

  // "active" marks a cycle that behaves as RUN: every RUN cycle, plus a
  // PAUSE cycle carrying a (new or pending) step request.
  assign active = (state == S_RUN) || ((state == S_PAUSE) && step_req);

  // Combinational controls so hazards act in the same cycle they appear.
  always_comb begin
    pc_en       = 1'b0;
    IF_ID_en    = 1'b0;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    halted      = 1'b0;
    running     = 1'b0;
    count_evt   = 1'b0;
    case (state)
      S_IDLE: begin
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
      end
      S_RUN, S_PAUSE: begin
        running = 1'b1;
        if (active) begin
          if (EX_halt) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
          end else if (EX_redirect) begin
            // PC loads the branch target; both younger stages are squashed.
            pc_en       = 1'b1;
            IF_ID_en    = 1'b1;
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
            count_evt   = 1'b1;
          end else if (load_use) begin
            ID_EX_flush = 1'b1;
            count_evt   = 1'b1;
          end else begin
            pc_en    = 1'b1;
            IF_ID_en = 1'b1;
          end
        end else begin
          // Paused with no step: nothing new issues, older stages drain.
          ID_EX_flush = 1'b1;
          if (EX_halt) begin
            IF_ID_flush = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
      end
      S_HALTED: begin
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
        halted      = 1'b1;
      end
      default: begin
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
      end
    endcase
  end

  // Sequencer state, drain countdown, pending step and the event counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
      step_pend <= 1'b0;
      event_cnt <= '0;
    end else begin
      if (count_evt && (event_cnt != {CNT_W{1'b1}})) begin
        event_cnt <= event_cnt + CNT_W'(1);
      end
      case (state)
        S_IDLE: begin
          step_pend <= 1'b0;
          if (start) begin
            state <= step_mode ? S_PAUSE : S_RUN;
          end
        end
        S_RUN: begin
          step_pend <= 1'b0;
          if (EX_halt) begin
            state     <= S_DRAIN;
            drain_cnt <= DW'(DRAIN_CYCLES);
          end else if (step_mode) begin
            state <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (EX_halt) begin
            state     <= S_DRAIN;
            drain_cnt <= DW'(DRAIN_CYCLES);
            step_pend <= 1'b0;
          end else if (!step_mode) begin
            state     <= S_RUN;
            step_pend <= 1'b0;
          end else begin
            // A redirect consumes the step; only a stall keeps it pending.
            step_pend <= step_req & ~EX_redirect & load_use;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DW'(1)) begin
            state <= S_HALTED;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        S_HALTED: begin
          state <= S_HALTED;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_sequencer
//
// Directed bench for pipe_hazard_sequencer. Inputs change just after each
// falling edge; outputs are sampled 1 ns later, well away from the rising
// edge. The six control outputs are packed as
// {pc_en, IF_ID_en, IF_ID_flush, ID_EX_flush, halted, running}.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_sequencer;

  localparam int CNT_W = 16;

  localparam logic [5:0] C_IDLE   = 6'b001100;
  localparam logic [5:0] C_RUN    = 6'b110001;
  localparam logic [5:0] C_STALL  = 6'b000101;
  localparam logic [5:0] C_REDIR  = 6'b111101;
  localparam logic [5:0] C_HALT   = 6'b001101;
  localparam logic [5:0] C_PAUSE  = 6'b000101;
  localparam logic [5:0] C_DRAIN  = 6'b001100;
  localparam logic [5:0] C_HALTED = 6'b001110;

  logic             clk;
  logic             reset;
  logic             start;
  logic             step_mode;
  logic             step;
  logic [1:0]       ID_rs1;
  logic [1:0]       ID_rs2;
  logic             ID_use_rs1;
  logic             ID_use_rs2;
  logic [1:0]       EX_rd;
  logic             EX_mem_read;
  logic             EX_redirect;
  logic             EX_halt;
  logic             pc_en;
  logic             IF_ID_en;
  logic             IF_ID_flush;
  logic             ID_EX_flush;
  logic             halted;
  logic             running;
  logic [CNT_W-1:0] event_cnt;
  logic [5:0]       ctrl;

  int checks = 0;
  int passes = 0;

  pipe_hazard_sequencer #(
    .DRAIN_CYCLES(2),
    .CNT_W       (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .step_mode  (step_mode),
    .step       (step),
    .ID_rs1     (ID_rs1),
    .ID_rs2     (ID_rs2),
    .ID_use_rs1 (ID_use_rs1),
    .ID_use_rs2 (ID_use_rs2),
    .EX_rd      (EX_rd),
    .EX_mem_read(EX_mem_read),
    .EX_redirect(EX_redirect),
    .EX_halt    (EX_halt),
    .pc_en      (pc_en),
    .IF_ID_en   (IF_ID_en),
    .IF_ID_flush(IF_ID_flush),
    .ID_EX_flush(ID_EX_flush),
    .halted     (halted),
    .running    (running),
    .event_cnt  (event_cnt)
  );

  assign ctrl = {pc_en, IF_ID_en, IF_ID_flush, ID_EX_flush, halted, running};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    start       = 1'b0;
    step        = 1'b0;
    ID_rs1      = 2'd0;
    ID_rs2      = 2'd0;
    ID_use_rs1  = 1'b0;
    ID_use_rs2  = 1'b0;
    EX_rd       = 2'd0;
    EX_mem_read = 1'b0;
    EX_redirect = 1'b0;
    EX_halt     = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    step_mode = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Reset state before any clock activity.
  task automatic test_reset();
    #1;
    checks++; if (ctrl !== C_IDLE) $display("[TB] FAIL reset_ctrl: got %b want %b", ctrl, C_IDLE); else passes++;
    checks++; if (event_cnt !== '0) $display("[TB] FAIL reset_cnt: got %0d want 0", event_cnt); else passes++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Start with no hazards: issue every cycle, no events.
  task automatic test_run_clean();
    do_reset();
    @(negedge clk);
    start = 1'b1;
    #1;
    checks++; if (ctrl !== C_IDLE) $display("[TB] FAIL start_cycle_ctrl: got %b want %b", ctrl, C_IDLE); else passes++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      checks++; if (ctrl !== C_RUN) $display("[TB] FAIL run_clean_%0d: got %b want %b", i, ctrl, C_RUN); else passes++;
    end
    checks++; if (event_cnt !== 16'd0) $display("[TB] FAIL run_clean_cnt: got %0d want 0", event_cnt); else passes++;
  endtask

  // Load-use stall on rs1, non-reading match, then rs2 stall.
  task automatic test_load_use();
    @(negedge clk);
    EX_mem_read = 1'b1; EX_rd = 2'd2; ID_use_rs1 = 1'b1; ID_rs1 = 2'd2;
    #1;
    checks++; if (ctrl !== C_STALL) $display("[TB] FAIL lu_rs1_stall: got %b want %b", ctrl, C_STALL); else passes++;
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (ctrl !== C_RUN) $display("[TB] FAIL lu_after: got %b want %b", ctrl, C_RUN); else passes++;
    checks++; if (event_cnt !== 16'd1) $display("[TB] FAIL lu_cnt1: got %0d want 1", event_cnt); else passes++;
    @(negedge clk);
    EX_mem_read = 1'b1; EX_rd = 2'd2; ID_use_rs1 = 1'b0; ID_rs1 = 2'd2; ID_rs2 = 2'd2;
    #1;
    checks++; if (ctrl !== C_RUN) $display("[TB] FAIL lu_unused_reg: got %b want %b", ctrl, C_RUN); else passes++;
    @(negedge clk);
    clear_inputs();
    EX_mem_read = 1'b1; EX_rd = 2'd3; ID_use_rs2 = 1'b1; ID_rs2 = 2'd3; ID_rs1 = 2'd3;
    #1;
    checks++; if (ctrl !== C_STALL) $display("[TB] FAIL lu_rs2_stall: got %b want %b", ctrl, C_STALL); else passes++;
    checks++; if (event_cnt !== 16'd1) $display("[TB] FAIL lu_nostall_cnt: got %0d want 1", event_cnt); else passes++;
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (event_cnt !== 16'd2) $display("[TB] FAIL lu_cnt2: got %0d want 2", event_cnt); else passes++;
  endtask

  // Redirect and load-use together: redirect wins, one event.
  task automatic test_redirect_load();
    @(negedge clk);
    EX_redirect = 1'b1; EX_mem_read = 1'b1; EX_rd = 2'd1; ID_use_rs1 = 1'b1; ID_rs1 = 2'd1;
    #1;
    checks++; if (ctrl !== C_REDIR) $display("[TB] FAIL redir_lu_ctrl: got %b want %b", ctrl, C_REDIR); else passes++;
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (ctrl !== C_RUN) $display("[TB] FAIL redir_after: got %b want %b", ctrl, C_RUN); else passes++;
    checks++; if (event_cnt !== 16'd3) $display("[TB] FAIL redir_cnt: got %0d want 3", event_cnt); else passes++;
  endtask

  // Halt with simultaneous redirect, two drain cycles, then halted for good.
  task automatic test_halt();
    @(negedge clk);
    EX_halt = 1'b1; EX_redirect = 1'b1;
    #1;
    checks++; if (ctrl !== C_HALT) $display("[TB] FAIL halt_ctrl: got %b want %b", ctrl, C_HALT); else passes++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      clear_inputs();
      EX_redirect = 1'b1; EX_mem_read = 1'b1; ID_use_rs1 = 1'b1;
      step_mode = (i == 0);
      #1;
      checks++; if (ctrl !== C_DRAIN) $display("[TB] FAIL drain_%0d: got %b want %b", i, ctrl, C_DRAIN); else passes++;
    end
    @(negedge clk);
    clear_inputs();
    step_mode = 1'b0;
    #1;
    checks++; if (ctrl !== C_HALTED) $display("[TB] FAIL halted_ctrl: got %b want %b", ctrl, C_HALTED); else passes++;
    checks++; if (event_cnt !== 16'd3) $display("[TB] FAIL halt_cnt: got %0d want 3", event_cnt); else passes++;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++; if (ctrl !== C_HALTED) $display("[TB] FAIL halted_start: got %b want %b", ctrl, C_HALTED); else passes++;
  endtask

  // Single-step: three steps, then a step arriving during a load-use stall.
  task automatic test_step();
    int issues;
    do_reset();
    step_mode = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++; if (ctrl !== C_PAUSE) $display("[TB] FAIL pause_ctrl: got %b want %b", ctrl, C_PAUSE); else passes++;
    issues = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      step = ((i % 5) == 0);
      #1;
      if (pc_en === 1'b1) issues++;
      if ((i % 5) == 0) begin
        checks++; if (ctrl !== C_RUN) $display("[TB] FAIL step_issue_%0d: got %b want %b", i, ctrl, C_RUN); else passes++;
      end
    end
    checks++; if (issues !== 3) $display("[TB] FAIL step_count: got %0d want 3", issues); else passes++;
    @(negedge clk);
    step = 1'b1; EX_mem_read = 1'b1; EX_rd = 2'd1; ID_use_rs2 = 1'b1; ID_rs2 = 2'd1;
    #1;
    checks++; if (ctrl !== C_STALL) $display("[TB] FAIL step_stall: got %b want %b", ctrl, C_STALL); else passes++;
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (ctrl !== C_RUN) $display("[TB] FAIL step_retry: got %b want %b", ctrl, C_RUN); else passes++;
    checks++; if (event_cnt !== 16'd1) $display("[TB] FAIL step_cnt: got %0d want 1", event_cnt); else passes++;
    @(negedge clk);
    step_mode = 1'b0;
    #1;
    checks++; if (ctrl !== C_PAUSE) $display("[TB] FAIL step_repause: got %b want %b", ctrl, C_PAUSE); else passes++;
    @(negedge clk);
    #1;
    checks++; if (ctrl !== C_RUN) $display("[TB] FAIL step_to_run: got %b want %b", ctrl, C_RUN); else passes++;
  endtask

  // Asynchronous reset in the middle of DRAIN.
  task automatic test_async_reset();
    do_reset();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    EX_redirect = 1'b1;
    @(negedge clk);
    clear_inputs();
    EX_halt = 1'b1;
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (event_cnt !== 16'd1) $display("[TB] FAIL ar_pre_cnt: got %0d want 1", event_cnt); else passes++;
    #2;
    reset = 1'b0;
    #1;
    checks++; if (ctrl !== C_IDLE) $display("[TB] FAIL ar_ctrl: got %b want %b", ctrl, C_IDLE); else passes++;
    checks++; if (event_cnt !== 16'd0) $display("[TB] FAIL ar_cnt: got %0d want 0", event_cnt); else passes++;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++; if (ctrl !== C_IDLE) $display("[TB] FAIL ar_wait_%0d: got %b want %b", i, ctrl, C_IDLE); else passes++;
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++; if (ctrl !== C_RUN) $display("[TB] FAIL ar_restart: got %b want %b", ctrl, C_RUN); else passes++;
  endtask

  initial begin
    reset     = 1'b0;
    step_mode = 1'b0;
    clear_inputs();
    test_reset();
    test_run_clean();
    test_load_use();
    test_redirect_load();
    test_halt();
    test_step();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
